// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port RAM with clear engine: state
// encoding, single-bit constants and lane-geometry helpers.
package ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam logic OFF = 1'b0;
    localparam logic ON  = 1'b1;

    // Number of write-enable lanes in a data word.
    function automatic int laneCount(input int bitWidth, input int laneWidth);
        return bitWidth / laneWidth;
    endfunction

    // True when the word splits into whole lanes; used by the elaboration check.
    function automatic bit lanesDivide(input int bitWidth, input int laneWidth);
        return (bitWidth % laneWidth) == 0;
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: the CLEAR/READY FSM plus the sweep counter that walks
// every address once, writing zero, after reset or on a clear request.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int SZB = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           clr,
    output logic           busy,
    output logic           clrWe,
    output logic [SZB-1:0] clrAddr
);

    localparam logic [SZB-1:0] LAST_ADDR = '1;

    state_e         stateQ;
    logic [SZB-1:0] cntQ;

    // Sweep every address in CLEAR, then wait in READY for a clear request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stateQ <= ST_CLEAR;
            cntQ   <= '0;
        end else begin
            case (stateQ)
                ST_CLEAR: begin
                    cntQ <= cntQ + 1'b1;
                    if (cntQ == LAST_ADDR) begin
                        stateQ <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (clr == ON) begin
                        stateQ <= ST_CLEAR;
                        cntQ   <= '0;
                    end
                end
                default: begin
                    stateQ <= ST_CLEAR;
                    cntQ   <= '0;
                end
            endcase
        end
    end

    assign busy    = (stateQ == ST_CLEAR);
    assign clrWe   = busy;
    assign clrAddr = cntQ;

endmodule

// File: rtl/ram_dp_clr.sv
// Simple-dual-port RAM with per-lane write enables and a sequential
// zero-fill engine. Optional macro RAM_DP_OUTREG_EN adds an output
// register stage (read latency 2 instead of 1).
module ram_dp_clr
    import ram_pkg::*;
#(
    parameter int BIT  = 8,
    parameter int SZB  = 4,
    parameter int LANE = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                clr,
    output logic                busy,
    input  logic                we,
    input  logic [BIT/LANE-1:0] wbe,
    input  logic [SZB-1:0]      waddr,
    input  logic [BIT-1:0]      d,
    input  logic                re,
    input  logic [SZB-1:0]      raddr,
    output logic [BIT-1:0]      q,
    output logic                qv
);

    localparam int NL  = laneCount(BIT, LANE);
    localparam int SZA = 1 << SZB;

    if (!lanesDivide(BIT, LANE)) begin : gLaneCheck
        $error("ram_dp_clr: BIT must be a multiple of LANE");
    end

    logic [BIT-1:0] mem [SZA];

    logic           clrWe;
    logic [SZB-1:0] clrAddr;
    logic           writeEn;
    logic           readEn;
    logic [BIT-1:0] readWord_d;
    logic [BIT-1:0] rdQ;
    logic           rdVldQ;

    ram_clear_seq #(
        .SZB (SZB)
    ) uClearSeq (
        .clock   (clock),
        .reset   (reset),
        .clr     (clr),
        .busy    (busy),
        .clrWe   (clrWe),
        .clrAddr (clrAddr)
    );

    assign writeEn = !busy && !clr && we;
    assign readEn  = !busy && !clr && re;

    // Read data with write-first forwarding of the lanes written this cycle.
    always_comb begin
        readWord_d = mem[raddr];
        if (writeEn && (waddr == raddr)) begin
            for (int l = 0; l < NL; l++) begin
                if (wbe[l]) begin
                    readWord_d[l*LANE +: LANE] = d[l*LANE +: LANE];
                end
            end
        end
    end

    // Array write port: the clear sweep owns it while busy, else lane writes.
    always_ff @(posedge clock) begin
        if (clrWe) begin
            mem[clrAddr] <= '0;
        end else if (writeEn) begin
            for (int l = 0; l < NL; l++) begin
                if (wbe[l]) begin
                    mem[waddr][l*LANE +: LANE] <= d[l*LANE +: LANE];
                end
            end
        end
    end

    // Array read register: captures on accepted reads, holds otherwise.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdQ    <= '0;
            rdVldQ <= OFF;
        end else begin
            rdVldQ <= readEn;
            if (readEn) begin
                rdQ <= readWord_d;
            end
        end
    end

`ifdef RAM_DP_OUTREG_EN
    logic [BIT-1:0] outQ;
    logic           outVldQ;

    // Output stage: delays read data one cycle, dropped once a sweep starts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outQ    <= '0;
            outVldQ <= OFF;
        end else begin
            outVldQ <= rdVldQ && !busy;
            if (rdVldQ && !busy) begin
                outQ <= rdQ;
            end
        end
    end

    assign q  = outQ;
    assign qv = outVldQ;
`else
    assign q  = rdQ;
    assign qv = rdVldQ;
`endif

endmodule

// File: tb/tb_ram_dp_clr.sv
// Self-checking bench for ram_dp_clr (BIT=16, LANE=8, SZB=4). Honours
// RAM_DP_OUTREG_EN for the expected read latency.
module tb_ram_dp_clr;

    localparam int BIT  = 16;
    localparam int SZB  = 4;
    localparam int LANE = 8;
    localparam int NL   = BIT / LANE;
    localparam int SZA  = 16;
`ifdef RAM_DP_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic           clock = 1'b0;
    logic           reset;
    logic           clr;
    logic           busy;
    logic           we;
    logic [NL-1:0]  wbe;
    logic [SZB-1:0] waddr;
    logic [BIT-1:0] d;
    logic           re;
    logic [SZB-1:0] raddr;
    logic [BIT-1:0] q;
    logic           qv;

    ram_dp_clr #(
        .BIT  (BIT),
        .SZB  (SZB),
        .LANE (LANE)
    ) dut (
        .clock (clock),
        .reset (reset),
        .clr   (clr),
        .busy  (busy),
        .we    (we),
        .wbe   (wbe),
        .waddr (waddr),
        .d     (d),
        .re    (re),
        .raddr (raddr),
        .q     (q),
        .qv    (qv)
    );

    always #5 clock = ~clock;

    // Reference model: memory image, remaining sweep edges, read pipeline.
    logic [BIT-1:0] refMem [SZA];
    int             sweepLeft;
    logic [BIT-1:0] refQ1, refQ;
    logic           refQv1, refQv;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic           we;
        logic [NL-1:0]  wbe;
        logic [SZB-1:0] waddr;
        logic [BIT-1:0] d;
        logic           re;
        logic [SZB-1:0] raddr;
        logic           chkQ;
        logic [BIT-1:0] expQ;
        logic           expQv;
    } vec_t;

    vec_t vecs [9];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic c, input logic w, input logic [NL-1:0] be,
                                 input logic [SZB-1:0] wa, input logic [BIT-1:0] wd,
                                 input logic r, input logic [SZB-1:0] ra);
        clr = c; we = w; wbe = be; waddr = wa; d = wd; re = r; raddr = ra;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic modelReset();
        sweepLeft = SZA;
        refQ1 = '0; refQv1 = 1'b0;
        refQ  = '0; refQv  = 1'b0;
    endtask

    // Advance the model by one rising edge using the current inputs.
    task automatic modelEdge();
        bit             wasBusy;
        logic [BIT-1:0] p1q;
        logic           p1v;
        wasBusy = (sweepLeft > 0);
        p1q = refQ1;
        p1v = refQv1;
        if (wasBusy) begin
            sweepLeft--;
            refQv1 = 1'b0;
            if (sweepLeft == 0) begin
                foreach (refMem[i]) refMem[i] = '0;
            end
        end else if (clr) begin
            sweepLeft = SZA;
            refQv1 = 1'b0;
        end else begin
            if (we) begin
                for (int l = 0; l < NL; l++) begin
                    if (wbe[l]) refMem[waddr][l*LANE +: LANE] = d[l*LANE +: LANE];
                end
            end
            refQv1 = re;
            if (re) refQ1 = refMem[raddr];
        end
        if (LAT == 2) begin
            refQv = p1v && !wasBusy;
            if (p1v && !wasBusy) refQ = p1q;
        end else begin
            refQ  = refQ1;
            refQv = refQv1;
        end
    endtask

    // One clock edge: model and DUT advance together, outputs compared after.
    task automatic step();
        modelEdge();
        @(posedge clock);
        #1;
        checkOutput("busy", busy, sweepLeft > 0);
        checkOutput("qv", qv, refQv);
        checkOutput("q", q, refQ);
    endtask

    task automatic applyReset();
        #2;
        reset = 1'b1;
        idle();
        modelReset();
        #1;
        checkOutput("reset_q", q, 0);
        checkOutput("reset_qv", qv, 0);
        checkOutput("reset_busy", busy, 1);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic countSweep(input string name, input int expEdges);
        int n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        checkOutput(name, n, expEdges);
    endtask

    task automatic readCheck(input string name, input logic [SZB-1:0] a, input logic [BIT-1:0] exp);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, a);
        step();
        idle();
        repeat (LAT - 1) step();
        checkOutput({name, "_qv"}, qv, 1);
        checkOutput({name, "_q"}, q, exp);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        modelReset();

        // Reset sweep: 16 busy edges, then every word reads zero.
        applyReset();
        countSweep("sweep_len", SZA);
        for (int a = 0; a < SZA; a++) readCheck($sformatf("zero%0d", a), a[SZB-1:0], 16'h0000);

        // Directed vectors: lane merge, write-first, no-op write, independence.
        vecs[0] = '{1'b1, 2'b11, 4'd3, 16'hABCD, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 2'b10, 4'd3, 16'h1200, 1'b0, 4'd0, 1'b0, 16'h0000, 1'b0};
        vecs[2] = '{1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd3, 1'b1, 16'h12CD, 1'b1};
        vecs[3] = '{1'b1, 2'b11, 4'd7, 16'h005A, 1'b1, 4'd7, 1'b1, 16'h005A, 1'b1};
        vecs[4] = '{1'b1, 2'b10, 4'd7, 16'hFF00, 1'b1, 4'd7, 1'b1, 16'hFF5A, 1'b1};
        vecs[5] = '{1'b1, 2'b00, 4'd7, 16'h1234, 1'b1, 4'd7, 1'b1, 16'hFF5A, 1'b1};
        vecs[6] = '{1'b1, 2'b11, 4'd8, 16'hBEEF, 1'b1, 4'd7, 1'b1, 16'hFF5A, 1'b1};
        vecs[7] = '{1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd8, 1'b1, 16'hBEEF, 1'b1};
        vecs[8] = '{1'b0, 2'b00, 4'd0, 16'h0000, 1'b1, 4'd0, 1'b1, 16'h0000, 1'b1};
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, vecs[i].we, vecs[i].wbe, vecs[i].waddr, vecs[i].d,
                          vecs[i].re, vecs[i].raddr);
            step();
            idle();
            repeat (LAT - 1) step();
            checkOutput($sformatf("vec%0d_qv", i), qv, vecs[i].expQv);
            if (vecs[i].chkQ) checkOutput($sformatf("vec%0d_q", i), q, vecs[i].expQ);
        end

        // Clear request with accesses attempted (and clr re-asserted) mid-sweep.
        applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
        step();
        begin
            int n = 0;
            while (busy && n < 100) begin
                applyStimulus((n % 3) == 0, 1'b1, 2'b11, 4'($urandom), 16'hFFFF, 1'b1, 4'($urandom));
                step();
                checkOutput("busy_qv", qv, 0);
                n++;
            end
            checkOutput("clr_sweep_len", n, SZA);
        end
        idle();
        for (int a = 0; a < SZA; a++) readCheck($sformatf("clr%0d", a), a[SZB-1:0], 16'h0000);

        // Mid-sweep reset clears q immediately and restarts a full sweep.
        applyStimulus(1'b0, 1'b1, 2'b11, 4'd5, 16'h3C3C, 1'b0, '0);
        step();
        readCheck("pre_rst", 4'd5, 16'h3C3C);
        applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b0, '0);
        step();
        idle();
        repeat (8) step();
        checkOutput("mid_busy", busy, 1);
        checkOutput("mid_q_held", q, 16'h3C3C);
        applyReset();
        countSweep("rst_sweep_len", SZA);

        // Back-to-back read stream: one qv per accepted re.
        applyStimulus(1'b0, 1'b1, 2'b11, 4'd2, 16'h003C, 1'b0, '0);
        step();
        readCheck("read3c", 4'd2, 16'h003C);
        begin
            int pulses = 0;
            for (int i = 0; i < 8; i++) begin
                applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 4'(i));
                step();
                if (qv) pulses++;
            end
            idle();
            repeat (LAT) begin
                step();
                if (qv) pulses++;
            end
            checkOutput("stream_pulses", pulses, 8);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom % 50) == 0, 1'($urandom), 2'($urandom),
                          4'($urandom_range(0, 3)), 16'($urandom),
                          1'($urandom), 4'($urandom_range(0, 3)));
            step();
        end
        idle();
        repeat (SZA + 2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
